colour_stop_ctrl: RTL
=====================

// Module: colour_stop_ctrl
// PURPOSE
//   Frame-rate decision stage downstream of the per-frame colour pixel counter.
//   - Consumes one colour pixel count per video frame (320x240, 76800 px).
//   - Applies multi-frame confirmation and hysteresis to the counts.
//   - Drives registered slow/stop commands to the waiter drive controller.
//   - Suppresses single-frame flicker from lighting and motion noise.
// PARAMETERS
//   COUNT_W        17         width of colour count and threshold inputs
//   ENTER_FRAMES   3          consecutive hit frames needed to assert stop (1..15)
//   EXIT_FRAMES    5          consecutive non-hit frames needed to release stop (1..15)
//   TIMEOUT_CYCLES 2_000_000  clk cycles without frame_done before FAULT (macro only)
// PORTS
//   clk           in   1        system clock
//   reset         in   1        synchronous, active-high
//   enable        in   1        0 = hold block in CLEAR and ignore frames
//   frame_done    in   1        1-cycle strobe: colour_count valid for a new frame
//   colour_count  in   COUNT_W  colour pixel count of the completed frame
//   stop_thresh   in   COUNT_W  hit when colour_count > stop_thresh
//   near_thresh   in   COUNT_W  near when colour_count > near_thresh (set < stop_thresh)
//   slow_cmd      out  1        request reduced speed
//   stop_cmd      out  1        request full stop
//   fault         out  1        frame watchdog expired (0 when macro off)
//   state_out     out  3        current FSM state encoding (debug)
//   last_count    out  COUNT_W  colour_count captured at the most recent frame_done
// BEHAVIOUR
//   - Reset: state=CLEAR, run counter=0, last_count=0; slow_cmd/stop_cmd/fault=0.
//   - Reset takes priority over every other input.
//   - Evaluation happens only in cycles with frame_done=1; otherwise the state holds.
//   - hit = colour_count > stop_thresh; near = colour_count > near_thresh.
//   - Comparisons are unsigned, strictly greater-than.
//   - State encodings: CLEAR=0, NEAR=1, CONFIRM=2, STOPPED=3, RELEASE=4, FAULT=5.
//   - CLEAR:
//     - hit: go to CONFIRM with run=1.
//     - If ENTER_FRAMES==1, a hit goes directly to STOPPED.
//     - near and not hit: go to NEAR.
//     - Otherwise stay in CLEAR.
//   - NEAR:
//     - hit: go to CONFIRM with run=1.
//     - not near: go to CLEAR.
//     - Otherwise stay in NEAR.
//   - CONFIRM:
//     - hit: run++; go to STOPPED when run+1 reaches ENTER_FRAMES.
//     - not hit: run=0; go to NEAR if near, else CLEAR.
//   - STOPPED:
//     - not hit: go to RELEASE with run=1.
//     - If EXIT_FRAMES==1, a non-hit goes directly to NEAR or CLEAR.
//     - hit: stay in STOPPED.
//   - RELEASE:
//     - hit: go to STOPPED with run=0.
//     - not hit: run++; when run+1 reaches EXIT_FRAMES, go to NEAR if near, else CLEAR.
//   - Outputs are registered, decoded from the next state, and valid the cycle after frame_done:
//     - slow_cmd=1 in NEAR and CONFIRM.
//     - stop_cmd=1 in STOPPED, RELEASE and FAULT.
//     - slow_cmd and stop_cmd are never both 1.
//   - last_count loads colour_count on every frame_done, regardless of enable.
//   - Run counter is 4 bits, saturates at 15 and never wraps. It clears on every state change.
//   - enable=0:
//     - Next cycle: state=CLEAR, run=0, slow_cmd=0, stop_cmd=0.
//     - Frames are ignored while low; fault is unaffected.
//   - enable rising together with frame_done: that frame is evaluated from CLEAR.
//   - Threshold inputs are sampled only on frame_done. Changing them mid-frame has no effect
//     until the next frame_done.
// CONFIGURATION
//   Macro COLOUR_STOP_TIMEOUT_EN:
//   - Defined:
//     - A 32-bit watchdog counts clk cycles since the last frame_done.
//     - The watchdog clears on frame_done and on reset.
//     - At TIMEOUT_CYCLES the block enters FAULT: fault=1, stop_cmd=1, slow_cmd=0.
//     - The next frame_done clears fault and evaluates that frame as if from CLEAR.
//     - enable=0 does not clear FAULT.
//   - Undefined:
//     - No watchdog logic; fault is tied to 0 and FAULT is unreachable.
// TESTING
//   1. Reset with stop=40000, near=20000; no frames -> state_out=0, all commands 0, last_count=0.
//   2. Frames 50000,50000,50000 -> slow_cmd=1 after frames 1-2; stop_cmd=1 one cycle after frame 3.
//   3. From STOPPED: 4 frames of 0, then 50000 -> stays stop_cmd=1 and returns to STOPPED;
//      then 5 frames of 0 -> state CLEAR and stop_cmd=0 after the 5th.
//   4. Frames 50000,10000,50000 -> never stops: CONFIRM, then CLEAR, then CONFIRM with run=1.
//      Also check boundary: count=40000 is not a hit, count=40001 is.
//   5. In CONFIRM: enable=0 for 1 cycle -> CLEAR, commands 0; a frame_done during enable=0
//      is ignored, but last_count still updates.
//   6. Macro on, TIMEOUT_CYCLES=100: no frame for 100 cycles -> fault=1, stop_cmd=1;
//      then frame 25000 -> fault=0, state NEAR, slow_cmd=1.
//      Macro off, same stimulus -> fault stays 0.

Source files
------------

// File: rtl/colour_stop_ctrl.sv
// Frame-rate stop/slow decision FSM with multi-frame confirmation and hysteresis.
// Optional frame watchdog (FAULT state) enabled by defining COLOUR_STOP_TIMEOUT_EN.
module colour_stop_ctrl #(
    parameter int COUNT_W      = 17,
    parameter int ENTER_FRAMES = 3,
    parameter int EXIT_FRAMES  = 5
`ifdef COLOUR_STOP_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 2_000_000
`endif
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               frame_done,
    input  logic [COUNT_W-1:0] colour_count,
    input  logic [COUNT_W-1:0] stop_thresh,
    input  logic [COUNT_W-1:0] near_thresh,
    output logic               slow_cmd,
    output logic               stop_cmd,
    output logic               fault,
    output logic [2:0]         state_out,
    output logic [COUNT_W-1:0] last_count
);

    typedef enum logic [2:0] {
        CLEAR   = 3'd0,
        NEAR    = 3'd1,
        CONFIRM = 3'd2,
        STOPPED = 3'd3,
        RELEASE = 3'd4,
        FAULT   = 3'd5
    } state_t;

    localparam logic [4:0] ENTER_N = 5'(ENTER_FRAMES);
    localparam logic [4:0] EXIT_N  = 5'(EXIT_FRAMES);

    state_t     state, next_state, eval_state, settle_state;
    logic [3:0] run, next_run;
    logic       hit, near, fault_trip;
    logic [4:0] run_plus1;

    function automatic logic [3:0] sat_inc(input logic [3:0] r);
        return (r == 4'd15) ? 4'd15 : r + 4'd1;
    endfunction

    assign hit          = colour_count > stop_thresh;
    assign near         = colour_count > near_thresh;
    assign run_plus1    = {1'b0, run} + 5'd1;
    assign settle_state = near ? NEAR : CLEAR;
    // A frame arriving in FAULT is judged as though the block were in CLEAR.
    assign eval_state   = (state == FAULT) ? CLEAR : state;
    assign state_out    = state;

`ifdef COLOUR_STOP_TIMEOUT_EN
    logic [31:0] wd_count;

    assign fault_trip = !frame_done && (wd_count + 32'd1 == 32'(TIMEOUT_CYCLES));

    always_ff @(posedge clk) begin
        if (reset || frame_done)
            wd_count <= '0;
        else if (wd_count != 32'(TIMEOUT_CYCLES))
            wd_count <= wd_count + 32'd1;
    end
`else
    assign fault_trip = 1'b0;
`endif

    always_comb begin
        next_state = state;
        next_run   = run;
        if (fault_trip) begin
            next_state = FAULT;
            next_run   = '0;
        end else if (!enable) begin
            // FAULT survives enable=0; everything else collapses to CLEAR.
            if (state != FAULT) begin
                next_state = CLEAR;
                next_run   = '0;
            end
        end else if (frame_done) begin
            next_run = '0;
            case (eval_state)
                CLEAR, NEAR: begin
                    if (hit) begin
                        if (ENTER_FRAMES == 1) begin
                            next_state = STOPPED;
                        end else begin
                            next_state = CONFIRM;
                            next_run   = 4'd1;
                        end
                    end else begin
                        next_state = settle_state;
                    end
                end
                CONFIRM: begin
                    if (!hit)
                        next_state = settle_state;
                    else if (run_plus1 >= ENTER_N)
                        next_state = STOPPED;
                    else begin
                        next_state = CONFIRM;
                        next_run   = sat_inc(run);
                    end
                end
                STOPPED: begin
                    if (hit)
                        next_state = STOPPED;
                    else if (EXIT_FRAMES == 1)
                        next_state = settle_state;
                    else begin
                        next_state = RELEASE;
                        next_run   = 4'd1;
                    end
                end
                RELEASE: begin
                    if (hit)
                        next_state = STOPPED;
                    else if (run_plus1 >= EXIT_N)
                        next_state = settle_state;
                    else begin
                        next_state = RELEASE;
                        next_run   = sat_inc(run);
                    end
                end
                default: next_state = CLEAR;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= CLEAR;
            run        <= '0;
            last_count <= '0;
            slow_cmd   <= 1'b0;
            stop_cmd   <= 1'b0;
            fault      <= 1'b0;
        end else begin
            state <= next_state;
            run   <= next_run;
            if (frame_done)
                last_count <= colour_count;
            // Commands decode the state being entered so they line up with it.
            slow_cmd <= (next_state == NEAR) || (next_state == CONFIRM);
            stop_cmd <= (next_state == STOPPED) || (next_state == RELEASE) ||
                        (next_state == FAULT);
`ifdef COLOUR_STOP_TIMEOUT_EN
            fault <= (next_state == FAULT);
`else
            fault <= 1'b0;
`endif
        end
    end

endmodule
